// File: rtl/gridx_div_pkg.sv
// Shared types for the per-core divide scheduler.
package gridx_div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } div_state_t;

   localparam logic [2:0] CORE_EXECUTE = 3'b101;

endpackage

// File: rtl/div_iter.sv
// Restoring divide datapath: one quotient bit per step.
// DIV_REMAINDER_EN exposes the next remainder value.
module div_iter #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [DATA_BITS-1:0] dvd_i,
   input  logic [DATA_BITS-1:0] dvs_i,
   output logic [DATA_BITS-1:0] quo_nxt_o,
`ifdef DIV_REMAINDER_EN
   output logic [DATA_BITS-1:0] rem_nxt_o,
`endif
   output logic                 last_o
);

   localparam int CW = $clog2(DATA_BITS) + 1;

   logic [DATA_BITS:0]   rem_q, rem_d, sh;
   logic [DATA_BITS-1:0] quo_q, quo_d, dvs_q;
   logic [CW-1:0]        cnt_q;

   // rem < divisor always, so the shifted value fits in DATA_BITS+1 bits
   always_comb begin
      sh = {rem_q[DATA_BITS-1:0], quo_q[DATA_BITS-1]};
      if (sh >= {1'b0, dvs_q}) begin
         rem_d = sh - {1'b0, dvs_q};
         quo_d = {quo_q[DATA_BITS-2:0], 1'b1};
      end else begin
         rem_d = sh;
         quo_d = {quo_q[DATA_BITS-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dvd_i;
         dvs_q <= dvs_i;
         cnt_q <= '0;
      end else if (step_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign quo_nxt_o = quo_d;
`ifdef DIV_REMAINDER_EN
   assign rem_nxt_o = rem_d[DATA_BITS-1:0];
`endif
   assign last_o = (cnt_q == CW'(DATA_BITS - 1));

endmodule

// File: rtl/alu_div_scheduler.sv
// Shared round-robin restoring divider for per-thread ALU DIV ops.
// Define DIV_REMAINDER_EN to add the remainder_flat output.
module alu_div_scheduler
   import gridx_div_pkg::*;
#(
   parameter int THREADS   = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [THREADS-1:0]           thread_enable,
   input  logic [THREADS-1:0]           start,
   input  logic [THREADS*DATA_BITS-1:0] rs_flat,
   input  logic [THREADS*DATA_BITS-1:0] rt_flat,
   output logic [THREADS*DATA_BITS-1:0] quotient_flat,
`ifdef DIV_REMAINDER_EN
   output logic [THREADS*DATA_BITS-1:0] remainder_flat,
`endif
   output logic [THREADS-1:0]           done,
   output logic [THREADS-1:0]           pending,
   output logic                         busy
);

   localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

   div_state_t                   state_q;
   logic [TW-1:0]                ptr_q, gnt;
   logic                         gnt_vld;
   logic [THREADS-1:0]           pending_q, done_q, acc, clr;
   logic [THREADS*DATA_BITS-1:0] quo_flat_q;
   logic [DATA_BITS-1:0]         rs_q [THREADS];
   logic [DATA_BITS-1:0]         rt_q [THREADS];
   logic [DATA_BITS-1:0]         quo_nxt;
   logic                         last, load, step;
   int                           j;
`ifdef DIV_REMAINDER_EN
   logic [THREADS*DATA_BITS-1:0] rem_flat_q;
   logic [DATA_BITS-1:0]         rem_nxt;
`endif

   // a thread finishing this cycle may immediately queue its next op
   assign acc = start & thread_enable & (~pending_q | done_q);

   always_comb begin
      gnt_vld = 1'b0;
      gnt     = ptr_q;
      j       = 0;
      for (int k = 1; k <= THREADS; k++) begin
         j = (int'(ptr_q) + k) % THREADS;
         if (!gnt_vld && pending_q[j]) begin
            gnt_vld = 1'b1;
            gnt     = TW'(j);
         end
      end
   end

   always_comb begin
      clr = '0;
      if (state_q == DIV_DONE) clr[ptr_q] = 1'b1;
   end

   assign load = (state_q == DIV_IDLE) && gnt_vld && (|rt_q[gnt]);
   assign step = (state_q == DIV_RUN);

   div_iter #(.DATA_BITS(DATA_BITS)) u_iter (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .step_i    (step),
      .dvd_i     (rs_q[gnt]),
      .dvs_i     (rt_q[gnt]),
      .quo_nxt_o (quo_nxt),
`ifdef DIV_REMAINDER_EN
      .rem_nxt_o (rem_nxt),
`endif
      .last_o    (last)
   );

   always_ff @(posedge clk) begin
      for (int i = 0; i < THREADS; i++) begin
         if (reset) begin
            rs_q[i] <= '0;
            rt_q[i] <= '0;
         end else if (acc[i]) begin
            rs_q[i] <= rs_flat[i*DATA_BITS +: DATA_BITS];
            rt_q[i] <= rt_flat[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DIV_IDLE;
         ptr_q      <= TW'(THREADS - 1);
         pending_q  <= '0;
         done_q     <= '0;
         quo_flat_q <= '0;
`ifdef DIV_REMAINDER_EN
         rem_flat_q <= '0;
`endif
      end else begin
         done_q    <= '0;
         pending_q <= (pending_q & ~clr) | acc;
         unique case (state_q)
            DIV_IDLE: begin
               if (gnt_vld) begin
                  ptr_q <= gnt;
                  if (rt_q[gnt] == '0) begin
                     state_q <= DIV_DONE;
                     done_q[gnt] <= 1'b1;
                     quo_flat_q[gnt*DATA_BITS +: DATA_BITS] <= '1;
`ifdef DIV_REMAINDER_EN
                     rem_flat_q[gnt*DATA_BITS +: DATA_BITS] <= rs_q[gnt];
`endif
                  end else begin
                     state_q <= DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               if (last) begin
                  state_q <= DIV_DONE;
                  done_q[ptr_q] <= 1'b1;
                  quo_flat_q[ptr_q*DATA_BITS +: DATA_BITS] <= quo_nxt;
`ifdef DIV_REMAINDER_EN
                  rem_flat_q[ptr_q*DATA_BITS +: DATA_BITS] <= rem_nxt;
`endif
               end
            end
            DIV_DONE: state_q <= DIV_IDLE;
            default:  state_q <= DIV_IDLE;
         endcase
      end
   end

   assign quotient_flat = quo_flat_q;
`ifdef DIV_REMAINDER_EN
   assign remainder_flat = rem_flat_q;
`endif
   assign done    = done_q;
   assign pending = pending_q;
   assign busy    = |pending_q;

endmodule

// File: tb/tb_alu_div_scheduler.sv
// Directed bench for alu_div_scheduler (THREADS=4, DATA_BITS=8).
module tb_alu_div_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  thread_enable, start, done, pending;
   logic [31:0] rs_flat, rt_flat, quotient_flat;
   logic        busy;
`ifdef DIV_REMAINDER_EN
   logic [31:0] remainder_flat;
`endif

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   alu_div_scheduler #(.THREADS(4), .DATA_BITS(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .thread_enable (thread_enable),
      .start         (start),
      .rs_flat       (rs_flat),
      .rt_flat       (rt_flat),
      .quotient_flat (quotient_flat),
`ifdef DIV_REMAINDER_EN
      .remainder_flat(remainder_flat),
`endif
      .done          (done),
      .pending       (pending),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] q_of(input int th);
      return quotient_flat[th*8 +: 8];
   endfunction

`ifdef DIV_REMAINDER_EN
   function automatic logic [7:0] r_of(input int th);
      return remainder_flat[th*8 +: 8];
   endfunction
`endif

   task automatic set_op(input int th, input int a, input int b);
      rs_flat[th*8 +: 8] = 8'(a);
      rt_flat[th*8 +: 8] = 8'(b);
   endtask

   task automatic pulse(input logic [3:0] m);
      start = m;
      tick();
      start = '0;
   endtask

   task automatic wait_done(input int th, input int n0, output int nout);
      nout = n0;
      while (!done[th] && nout < 60) begin
         tick();
         nout++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int tdone [4];
      int seq [4];
      int k, cnt;
      thread_enable = 4'b1111;
      rs_flat = '0;
      rt_flat = '0;
      start = '0;
      do_reset();

      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_quot", quotient_flat, 32'h0);

      // 1: 100/7
      set_op(0, 100, 7);
      pulse(4'b0001);
      chk("t1_pending", 32'(pending), 32'h1);
      wait_done(0, 1, n);
      chk("t1_lat", 32'(n), 32'd10);
      chk("t1_quot", 32'(q_of(0)), 32'd14);
`ifdef DIV_REMAINDER_EN
      chk("t1_rem", 32'(r_of(0)), 32'd2);
`endif
      tick();
      chk("t1_done_pulse", 32'(done), 32'h0);
      chk("t1_idle", 32'(busy), 32'h0);

      // 2: divide by zero
      set_op(2, 9, 0);
      pulse(4'b0100);
      wait_done(2, 1, n);
      chk("t2_lat", 32'(n), 32'd2);
      chk("t2_quot", 32'(q_of(2)), 32'hFF);
`ifdef DIV_REMAINDER_EN
      chk("t2_rem", 32'(r_of(2)), 32'd9);
`endif

      // disabled thread ignores start
      thread_enable = 4'b1011;
      set_op(2, 5, 1);
      pulse(4'b0100);
      chk("en_pending", 32'(pending), 32'h0);
      thread_enable = 4'b1111;

      // 3: all four at once from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_op(i, 200, 10);
         tdone[i] = 0;
      end
      pulse(4'b1111);
      chk("t3_pending", 32'(pending), 32'hF);
      n = 1;
      while (n <= 50) begin
         for (int i = 0; i < 4; i++) begin
            if (done[i]) begin
               tdone[i] = n;
               chk("t3_quot", 32'(q_of(i)), 32'd20);
            end
         end
         if (n == 41) chk("t3_busy_after", 32'(busy), 32'h0);
         tick();
         n++;
      end
      for (int i = 0; i < 4; i++)
         chk("t3_order", 32'(tdone[i]), 32'(10 * (i + 1)));

      // 4: restart while pending is ignored; restart in done cycle is kept
      set_op(1, 50, 5);
      pulse(4'b0010);
      set_op(1, 99, 3);
      pulse(4'b0010);
      wait_done(1, 2, n);
      chk("t4_lat", 32'(n), 32'd10);
      chk("t4_quot", 32'(q_of(1)), 32'd10);
      set_op(1, 60, 4);
      pulse(4'b0010);
      wait_done(1, 1, n);
      chk("t4_lat2", 32'(n), 32'd10);
      chk("t4_quot2", 32'(q_of(1)), 32'd15);
      tick();

      // 5: fairness between 0 and 3
      do_reset();
      set_op(0, 21, 3);
      set_op(3, 255, 16);
      start = 4'b1001;
      tick();
      n = 1;
      k = 0;
      while (k < 4 && n < 80) begin
         for (int i = 0; i < 4; i++) begin
            if (done[i]) begin
               seq[k] = i;
               tdone[k] = n;
               k++;
            end
         end
         tick();
         n++;
      end
      start = '0;
      chk("t5_count", 32'(k), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t5_seq", 32'(seq[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
         chk("t5_time", 32'(tdone[i]), 32'(10 * (i + 1)));
      end
      chk("t5_q0", 32'(q_of(0)), 32'd7);
      chk("t5_q3", 32'(q_of(3)), 32'd15);
`ifdef DIV_REMAINDER_EN
      chk("t5_r3", 32'(r_of(3)), 32'd15);
`endif
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("t5_drain", 32'(busy), 32'h0);

      // 6: reset in the middle of a divide
      set_op(1, 100, 7);
      pulse(4'b0010);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_pending", 32'(pending), 32'h0);
      chk("t6_done", 32'(done), 32'h0);
      chk("t6_quot", quotient_flat, 32'h0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done != 0) cnt++;
         tick();
      end
      chk("t6_no_done", 32'(cnt), 32'd0);
      set_op(0, 100, 7);
      pulse(4'b0001);
      wait_done(0, 1, n);
      chk("t6_lat", 32'(n), 32'd10);
      chk("t6_quot2", 32'(q_of(0)), 32'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
